// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: branch opcodes, PC control codes and FSM states shared by the PC and pc_ctrl.
package pc_ctrl_pkg;
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_COND = 3'b001;
  localparam logic [2:0] BR_JMP  = 3'b010;
  localparam logic [2:0] BR_ABS  = 3'b011;
  localparam logic [2:0] BR_HALT = 3'b111;
  localparam logic [2:0] PC_INC  = 3'b000;
  localparam logic [2:0] PC_COND = 3'b001;
  localparam logic [2:0] PC_JMP  = 3'b010;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;
  function automatic logic is_branch(input logic [2:0] op);
    return op == BR_COND || op == BR_JMP || op == BR_ABS;
  endfunction
endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: decode-side inputs (master drives) and PC-control outputs (slave drives) of pc_ctrl.
interface pc_ctrl_if #(parameter int D = 12, parameter int LUT_N = 16);
  localparam int IW = $clog2(LUT_N);
  logic          instr_valid;
  logic [2:0]    br_op;
  logic [IW-1:0] lut_idx;
  logic          cond_sel;
  logic          flag_we;
  logic          alu_zero;
  logic          alu_neg;
  logic          lut_we;
  logic [IW-1:0] lut_wr_idx;
  logic [D-1:0]  lut_wr_data;
  logic          start;
  logic [D-1:0]  prog_ctr;
  logic [2:0]    branch;
  logic [D-1:0]  target;
  logic          jcnd;
  logic          flush;
  logic          halted;
  logic [15:0]   redirect_cnt;
  modport master (
    output instr_valid, br_op, lut_idx, cond_sel, flag_we, alu_zero, alu_neg,
           lut_we, lut_wr_idx, lut_wr_data, start, prog_ctr,
    input  branch, target, jcnd, flush, halted, redirect_cnt
  );
  modport slave (
    input  instr_valid, br_op, lut_idx, cond_sel, flag_we, alu_zero, alu_neg,
           lut_we, lut_wr_idx, lut_wr_data, start, prog_ctr,
    output branch, target, jcnd, flush, halted, redirect_cnt
  );
endinterface

// File: rtl/pc_ctrl_jump_lut.sv
// jump_lut: jump-target table; sync write, async read (old data on same-index write), async-reset clear.
module jump_lut #(
  parameter int D = 12,
  parameter int LUT_N = 16,
  localparam int IW = $clog2(LUT_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [D-1:0]  wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [D-1:0]  rd_data
);
  logic [D-1:0] mem [LUT_N];
  always_ff @(posedge clk or posedge reset)
    if (reset) mem <= '{default: '0};
    else if (we) mem[wr_idx] <= wr_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: branch/flush/halt control for the PC. Ports: clk, reset (async, active-high), bus (pc_ctrl_if.slave).
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int D = 12,
  parameter int LUT_N = 16
) (
  input logic     clk,
  input logic     reset,
  pc_ctrl_if.slave bus
);
  state_t       state;
  logic         flag_z, flag_n;
  logic [15:0]  cnt_q;
  logic [D-1:0] lut_rd;
  logic         run, hlt, is_br, sel_flag, taken, halt_req;
  jump_lut #(.D(D), .LUT_N(LUT_N)) u_lut (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.lut_we),
    .wr_idx (bus.lut_wr_idx),
    .wr_data(bus.lut_wr_data),
    .rd_idx (bus.lut_idx),
    .rd_data(lut_rd)
  );
  // reset gating keeps outputs quiet while reset is held even though RUN decodes inputs combinationally
  assign run      = state == ST_RUN && !reset;
  assign hlt      = state == ST_HALT && !reset;
  assign sel_flag = bus.cond_sel ? flag_n : flag_z;
  assign is_br    = run && bus.instr_valid && is_branch(bus.br_op);
  assign taken    = is_br && (bus.br_op != BR_COND || sel_flag);
  assign halt_req = run && bus.instr_valid && bus.br_op == BR_HALT;
  assign bus.branch       = is_br ? bus.br_op : hlt ? PC_JMP : PC_INC;
  assign bus.target       = is_br ? lut_rd : hlt ? bus.prog_ctr : '0;
  assign bus.jcnd         = is_br && sel_flag;
  assign bus.flush        = state == ST_FLUSH && !reset;
  assign bus.halted       = hlt;
  assign bus.redirect_cnt = cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= ST_RUN;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (bus.flag_we) begin
        flag_z <= bus.alu_zero;
        flag_n <= bus.alu_neg;
      end
      if (taken && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      state <= state == ST_RUN   ? (taken ? ST_FLUSH : halt_req ? ST_HALT : ST_RUN) :
               state == ST_FLUSH ? ST_RUN :
               bus.start         ? ST_RUN : ST_HALT;
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl.
module tb_pc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  pc_ctrl_if #(.D(12), .LUT_N(16)) bus ();
  pc_ctrl #(.D(12), .LUT_N(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.br_op = 3'b000;
    bus.flag_we = 1'b0;
    bus.lut_we = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic op(input logic [2:0] o, input logic [3:0] idx, input logic cs);
    bus.instr_valid = 1'b1;
    bus.br_op = o;
    bus.lut_idx = idx;
    bus.cond_sel = cs;
  endtask
  initial begin
    bus.instr_valid = 1'b0; bus.br_op = 3'b000; bus.lut_idx = '0; bus.cond_sel = 1'b0;
    bus.flag_we = 1'b0; bus.alu_zero = 1'b0; bus.alu_neg = 1'b0;
    bus.lut_we = 1'b0; bus.lut_wr_idx = '0; bus.lut_wr_data = '0;
    bus.start = 1'b0; bus.prog_ctr = '0;
    #3;
    chk("rst_branch", 32'(bus.branch), 32'h0);
    chk("rst_target", 32'(bus.target), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_cnt", 32'(bus.redirect_cnt), 32'h0);
    op(3'b010, 4'd3, 1'b0);
    #1;
    chk("rst_gate_branch", 32'(bus.branch), 32'h0);
    chk("rst_gate_jcnd", 32'(bus.jcnd), 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2 chk("idle_branch", 32'(bus.branch), 32'h0);
      tick();
    end
    chk("idle_cnt", 32'(bus.redirect_cnt), 32'h0);
    bus.lut_we = 1'b1; bus.lut_wr_idx = 4'd3; bus.lut_wr_data = 12'h00A;
    op(3'b010, 4'd3, 1'b0);
    #2;
    chk("rdw_branch", 32'(bus.branch), 32'h2);
    chk("rdw_old_target", 32'(bus.target), 32'h0);
    tick();
    op(3'b010, 4'd3, 1'b0);
    #2;
    chk("flush1", 32'(bus.flush), 32'h1);
    chk("flush1_branch", 32'(bus.branch), 32'h0);
    chk("flush1_target", 32'(bus.target), 32'h0);
    chk("cnt1", 32'(bus.redirect_cnt), 32'h1);
    tick();
    chk("flush_one_cycle", 32'(bus.flush), 32'h0);
    chk("flush_ignored_cnt", 32'(bus.redirect_cnt), 32'h1);
    op(3'b010, 4'd3, 1'b0);
    #2;
    chk("jmp_branch", 32'(bus.branch), 32'h2);
    chk("jmp_target", 32'(bus.target), 32'h00A);
    tick();
    chk("jmp_flush", 32'(bus.flush), 32'h1);
    chk("cnt2", 32'(bus.redirect_cnt), 32'h2);
    tick();
    bus.flag_we = 1'b1; bus.alu_zero = 1'b1; bus.alu_neg = 1'b0;
    tick();
    op(3'b001, 4'd3, 1'b0);
    #2;
    chk("cz_jcnd1", 32'(bus.jcnd), 32'h1);
    chk("cz_branch", 32'(bus.branch), 32'h1);
    chk("cz_target", 32'(bus.target), 32'h00A);
    tick();
    chk("cz_flush", 32'(bus.flush), 32'h1);
    chk("cnt3", 32'(bus.redirect_cnt), 32'h3);
    tick();
    bus.flag_we = 1'b1; bus.alu_zero = 1'b0;
    tick();
    op(3'b001, 4'd3, 1'b0);
    #2 chk("cz_jcnd0", 32'(bus.jcnd), 32'h0);
    tick();
    chk("cz_noflush", 32'(bus.flush), 32'h0);
    chk("cz_nocnt", 32'(bus.redirect_cnt), 32'h3);
    bus.flag_we = 1'b1; bus.alu_zero = 1'b1;
    op(3'b001, 4'd3, 1'b0);
    #2 chk("fwd_old_flag", 32'(bus.jcnd), 32'h0);
    tick();
    chk("fwd_noflush", 32'(bus.flush), 32'h0);
    op(3'b001, 4'd3, 1'b1);
    #2 chk("neg_jcnd0", 32'(bus.jcnd), 32'h0);
    tick();
    op(3'b001, 4'd3, 1'b0);
    #2 chk("fwd_new_flag", 32'(bus.jcnd), 32'h1);
    tick();
    chk("fwd_flush", 32'(bus.flush), 32'h1);
    chk("cnt4", 32'(bus.redirect_cnt), 32'h4);
    tick();
    bus.flag_we = 1'b1; bus.alu_zero = 1'b0; bus.alu_neg = 1'b1;
    tick();
    op(3'b001, 4'd3, 1'b1);
    #2 chk("neg_jcnd1", 32'(bus.jcnd), 32'h1);
    tick();
    chk("cnt5", 32'(bus.redirect_cnt), 32'h5);
    tick();
    bus.prog_ctr = 12'h025;
    op(3'b111, 4'd3, 1'b0);
    #2;
    chk("halt_req_branch", 32'(bus.branch), 32'h0);
    chk("halt_req_halted", 32'(bus.halted), 32'h0);
    tick();
    chk("halted", 32'(bus.halted), 32'h1);
    chk("halt_branch", 32'(bus.branch), 32'h2);
    chk("halt_target", 32'(bus.target), 32'h025);
    op(3'b010, 4'd3, 1'b0);
    #2 chk("halt_ign_target", 32'(bus.target), 32'h025);
    tick();
    chk("halt_hold", 32'(bus.halted), 32'h1);
    bus.start = 1'b1;
    #2 chk("halt_start_same", 32'(bus.halted), 32'h1);
    tick();
    chk("resume_halted", 32'(bus.halted), 32'h0);
    chk("resume_branch", 32'(bus.branch), 32'h0);
    chk("halt_cnt", 32'(bus.redirect_cnt), 32'h5);
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    #1 chk("sat_force", 32'(bus.redirect_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      op(3'b011, 4'd3, 1'b0);
      tick();
      chk("sat_cnt", 32'(bus.redirect_cnt), 32'hFFFF);
      tick();
    end
    op(3'b010, 4'd3, 1'b0);
    tick();
    chk("pre_rst_flush", 32'(bus.flush), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_flush", 32'(bus.flush), 32'h0);
    chk("async_rst_cnt", 32'(bus.redirect_cnt), 32'h0);
    tick();
    reset = 1'b0;
    op(3'b111, 4'd0, 1'b0);
    tick();
    chk("pre_rst_halted", 32'(bus.halted), 32'h1);
    #1 reset = 1'b1;
    #1 chk("async_rst_halted", 32'(bus.halted), 32'h0);
    tick();
    reset = 1'b0;
    op(3'b010, 4'd3, 1'b0);
    #2 chk("lut_cleared", 32'(bus.target), 32'h0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
